// File: rtl/pseudo_spi_xfer_engine_if.sv
// Bus bundle between the pseudo-SPI transfer engine, the SRAM port mux and the scan pins.
// The engine connects through the slave modport; the controlling side uses master.
interface pseudo_spi_xfer_engine_if #(
  parameter int MEM_DW = 8,
  parameter int MEM_AW = 9,
  parameter int LEN_W  = 8,
  parameter int DIV_W  = 8
);
  logic              BGN;
  logic              MODE;
  logic              MSB_FIRST;
  logic [MEM_AW-1:0] ADDR_BGN;
  logic [LEN_W-1:0]  DATA_LEN;
  logic [DIV_W-1:0]  FREQ_DIV;
  logic [MEM_DW-1:0] PI;
  logic              SPI_SI;
  logic              SCLK1;
  logic              SCLK2;
  logic              LAT;
  logic              SPI_SO;
  logic [MEM_AW-1:0] A;
  logic [MEM_DW-1:0] PO;
  logic              CEN;
  logic              D_WE;
  logic              BUSY;
  logic              spi_is_done;

  modport slave (
    input  BGN, MODE, MSB_FIRST, ADDR_BGN, DATA_LEN, FREQ_DIV, PI, SPI_SI,
    output SCLK1, SCLK2, LAT, SPI_SO, A, PO, CEN, D_WE, BUSY, spi_is_done
  );

  modport master (
    output BGN, MODE, MSB_FIRST, ADDR_BGN, DATA_LEN, FREQ_DIV, PI, SPI_SI,
    input  SCLK1, SCLK2, LAT, SPI_SO, A, PO, CEN, D_WE, BUSY, spi_is_done
  );
endinterface

// File: rtl/pseudo_spi_xfer_engine.sv
// Pseudo-SPI block transfer engine: streams SRAM words out over a two-phase serial clock
// (read mode) or captures serial words into SRAM (write mode).
module pseudo_spi_xfer_engine #(
  parameter int MEM_DW = 8,
  parameter int MEM_AW = 9,
  parameter int LEN_W  = 8,
  parameter int DIV_W  = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  pseudo_spi_xfer_engine_if.slave  bus
);

  localparam int BW = (MEM_DW > 1) ? $clog2(MEM_DW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(MEM_DW - 1);

  typedef enum logic [2:0] {IDLE, ADDR, READ, SHIFT, WRITE, LATCH, DONE} state_t;

  state_t            state, state_nxt;
  logic [MEM_AW-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [DIV_W-1:0]  div;
  logic              mode;
  logic              msb_first;
  logic [MEM_DW-1:0] sreg;
  logic              phase;
  logic [DIV_W-1:0]  phase_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [LEN_W:0]    word_cnt;

  logic              phase_end;
  logic              bit_end;
  logic              last_bit;
  logic              last_word;
  logic              si_bit;
  logic [MEM_DW-1:0] sreg_shifted;

  assign phase_end = (phase_cnt == div);
  assign bit_end   = phase & phase_end;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign last_word = (word_cnt == {1'b0, len});
  assign si_bit    = mode & bus.SPI_SI;

  // The same shift direction serves both modes: the outgoing bit leaves from the
  // end selected by msb_first and the incoming bit enters at the opposite end.
  assign sreg_shifted = msb_first ? {sreg[MEM_DW-2:0], si_bit} : {si_bit, sreg[MEM_DW-1:1]};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.BGN) state_nxt = bus.MODE ? SHIFT : ADDR;
      ADDR:    state_nxt = READ;
      READ:    state_nxt = SHIFT;
      SHIFT:   if (bit_end && last_bit) state_nxt = mode ? WRITE : (last_word ? LATCH : ADDR);
      WRITE:   state_nxt = last_word ? DONE : SHIFT;
      LATCH:   if (phase_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer parameters are frozen at start so pin changes mid-block have no effect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr      <= '0;
      len       <= '0;
      div       <= '0;
      mode      <= 1'b0;
      msb_first <= 1'b0;
      sreg      <= '0;
      phase     <= 1'b0;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.BGN) begin
            addr      <= bus.ADDR_BGN;
            len       <= bus.DATA_LEN;
            div       <= bus.FREQ_DIV;
            mode      <= bus.MODE;
            msb_first <= bus.MSB_FIRST;
            sreg      <= '0;
            phase     <= 1'b0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
          end
        end
        READ: sreg <= bus.PI;
        SHIFT: begin
          if (phase_end) begin
            phase_cnt <= '0;
            phase     <= ~phase;
            if (phase) begin
              sreg    <= sreg_shifted;
              bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
              if (last_bit && !mode && !last_word) begin
                word_cnt <= word_cnt + (LEN_W+1)'(1);
                addr     <= addr + MEM_AW'(1);
              end
            end
          end else begin
            phase_cnt <= phase_cnt + DIV_W'(1);
          end
        end
        WRITE: begin
          if (!last_word) begin
            word_cnt <= word_cnt + (LEN_W+1)'(1);
            addr     <= addr + MEM_AW'(1);
          end
        end
        LATCH: phase_cnt <= phase_cnt + DIV_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.SCLK1       = 1'b0;
    bus.SCLK2       = 1'b0;
    bus.LAT         = 1'b0;
    bus.SPI_SO      = 1'b0;
    bus.A           = '0;
    bus.PO          = '0;
    bus.CEN         = 1'b1;
    bus.D_WE        = 1'b0;
    bus.BUSY        = (state != IDLE);
    bus.spi_is_done = (state == DONE);
    if (state == SHIFT) begin
      bus.SCLK1 = ~phase;
      bus.SCLK2 = phase;
      if (!mode) bus.SPI_SO = msb_first ? sreg[MEM_DW-1] : sreg[0];
    end
    if (state == ADDR || state == READ || state == WRITE) bus.A = addr;
    if (state == ADDR) bus.CEN = 1'b0;
    if (state == WRITE) begin
      bus.CEN  = 1'b0;
      bus.D_WE = 1'b1;
      bus.PO   = sreg;
    end
    // Write mode holds LAT as a select across the whole block; read mode pulses it at the end.
    if (mode) bus.LAT = (state == SHIFT) || (state == WRITE) || (state == DONE);
    else      bus.LAT = (state == LATCH);
  end

endmodule

// File: tb/tb_pseudo_spi_xfer_engine.sv
// Self-checking bench for pseudo_spi_xfer_engine with a behavioural SRAM and serial monitor.
module tb_pseudo_spi_xfer_engine;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pseudo_spi_xfer_engine_if bus ();

  pseudo_spi_xfer_engine dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // Synchronous SRAM model with a side port used only for preloading while the DUT is idle.
  logic [7:0] mem [0:511];
  logic       pre_we;
  logic [8:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!bus.CEN) begin
      if (bus.D_WE) mem[bus.A] <= bus.PO;
      else          bus.PI <= mem[bus.A];
    end
  end

  int checks = 0;
  int errors = 0;

  logic       so_bits [$];
  logic [8:0] a_seq [$];
  logic [7:0] tx_bytes [$];
  int we_cycles, lat_pulses, lat_cycles, lat_gap, bad_runs, overlaps, done_cyc;

  typedef struct {
    bit         mode;
    bit         msb;
    logic [8:0] addr;
    logic [7:0] div;
    logic [7:0] data;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    @(negedge CLK);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  function automatic logic [7:0] so_byte(input int w);
    logic [7:0] b;
    b = 'x;
    for (int i = 0; i < 8; i++)
      if (8*w + i < so_bits.size()) b[7-i] = so_bits[8*w + i];
    return b;
  endfunction

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, " ctl"}, {24'd0, bus.SCLK1, bus.SCLK2, bus.LAT, bus.SPI_SO, bus.D_WE,
                                bus.BUSY, bus.spi_is_done, bus.CEN}, 32'h01);
    checkOutput({tag, " A"}, {23'd0, bus.A}, 32'd0);
    checkOutput({tag, " PO"}, {24'd0, bus.PO}, 32'd0);
  endtask

  // Starts one transfer and monitors it cycle by cycle until spi_is_done or the cycle budget.
  task automatic applyStimulus(input bit mode, input bit msb, input logic [8:0] addr,
                               input logic [7:0] len, input logic [7:0] div, input bit disturb);
    logic       prev1, prev2, prevlat;
    logic [7:0] tmp;
    int run1, run2, si_idx;
    so_bits.delete(); a_seq.delete();
    we_cycles = 0; lat_pulses = 0; lat_cycles = 0; lat_gap = 0;
    bad_runs = 0; overlaps = 0; done_cyc = -1;
    prev1 = 1'b0; prev2 = 1'b0; prevlat = 1'b0; run1 = 0; run2 = 0; si_idx = 0;
    @(negedge CLK);
    bus.MODE = mode; bus.MSB_FIRST = msb; bus.ADDR_BGN = addr;
    bus.DATA_LEN = len; bus.FREQ_DIV = div; bus.BGN = 1'b1;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      @(posedge CLK); #1;
      if (disturb && cyc >= 2 && cyc <= 30) begin
        bus.BGN = cyc[0];
        bus.ADDR_BGN = 9'd3; bus.DATA_LEN = 8'd0; bus.FREQ_DIV = 8'd2;
        bus.MODE = ~mode; bus.MSB_FIRST = ~msb;
      end else begin
        bus.BGN = 1'b0;
      end
      if (bus.SCLK1 && bus.SCLK2) overlaps++;
      if (bus.SCLK1 && !prev1) begin
        if (!mode) so_bits.push_back(bus.SPI_SO);
        else begin
          if (si_idx / 8 < tx_bytes.size()) begin
            tmp = tx_bytes[si_idx / 8];
            bus.SPI_SI = tmp[7 - si_idx % 8];
          end
          si_idx++;
        end
      end
      if (bus.SCLK1) run1++;
      else if (prev1) begin
        if (run1 != int'(div) + 1) bad_runs++;
        run1 = 0;
      end
      if (bus.SCLK2) run2++;
      else if (prev2) begin
        if (run2 != int'(div) + 1) bad_runs++;
        run2 = 0;
      end
      if (!bus.CEN && !bus.D_WE) a_seq.push_back(bus.A);
      if (bus.D_WE) we_cycles++;
      if (bus.LAT) lat_cycles++;
      if (bus.LAT && !prevlat) lat_pulses++;
      if (mode && bus.BUSY && !bus.LAT) lat_gap++;
      prev1 = bus.SCLK1; prev2 = bus.SCLK2; prevlat = bus.LAT;
      if (bus.spi_is_done) begin
        done_cyc = cyc;
        break;
      end
    end
    @(posedge CLK); #1;
    checkOutput("idle after done", {31'd0, bus.BUSY}, 32'd0);
  endtask

  initial begin
    int         a_bad;
    logic [7:0] exp14 [14];
    logic [8:0] wrap_a [4];
    logic [7:0] wrap_d [4];

    RST = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.BGN = 1'b0; bus.MODE = 1'b0; bus.MSB_FIRST = 1'b0; bus.ADDR_BGN = '0;
    bus.DATA_LEN = '0; bus.FREQ_DIV = '0; bus.SPI_SI = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;

    // Single-word vectors; exp is the SO stream packed first-bit-at-7 (read) or the stored word (write).
    vecs[0] = '{1'b0, 1'b0, 9'd0,   8'd3, 8'hAB, 8'hD5, 71};
    vecs[1] = '{1'b0, 1'b1, 9'd5,   8'd0, 8'h96, 8'h96, 20};
    vecs[2] = '{1'b0, 1'b0, 9'd7,   8'd1, 8'h01, 8'h80, 37};
    vecs[3] = '{1'b1, 1'b1, 9'd120, 8'd0, 8'h3C, 8'h3C, 18};
    vecs[4] = '{1'b1, 1'b0, 9'd200, 8'd2, 8'hC1, 8'h83, 50};

    for (int v = 0; v < 5; v++) begin
      if (!vecs[v].mode) preload(vecs[v].addr, vecs[v].data);
      else begin
        preload(vecs[v].addr, ~vecs[v].exp);
        tx_bytes.delete();
        tx_bytes.push_back(vecs[v].data);
      end
      applyStimulus(vecs[v].mode, vecs[v].msb, vecs[v].addr, 8'd0, vecs[v].div, 1'b0);
      checkOutput($sformatf("v%0d latency", v), done_cyc, vecs[v].lat);
      checkOutput($sformatf("v%0d overlap", v), overlaps, 0);
      checkOutput($sformatf("v%0d phase len", v), bad_runs, 0);
      if (!vecs[v].mode) begin
        checkOutput($sformatf("v%0d so", v), {24'd0, so_byte(0)}, {24'd0, vecs[v].exp});
        checkOutput($sformatf("v%0d a count", v), a_seq.size(), 1);
        if (a_seq.size() > 0)
          checkOutput($sformatf("v%0d a", v), {23'd0, a_seq[0]}, {23'd0, vecs[v].addr});
        checkOutput($sformatf("v%0d lat pulses", v), lat_pulses, 1);
        checkOutput($sformatf("v%0d lat width", v), lat_cycles, int'(vecs[v].div) + 1);
      end else begin
        checkOutput($sformatf("v%0d mem", v), {24'd0, mem[vecs[v].addr]}, {24'd0, vecs[v].exp});
        checkOutput($sformatf("v%0d we cycles", v), we_cycles, 1);
        checkOutput($sformatf("v%0d lat gap", v), lat_gap, 0);
      end
    end

    // 14-word MSB-first block read from address 32.
    for (int k = 0; k < 14; k++) begin
      exp14[k] = 8'(k * 37 + 5);
      preload(9'(32 + k), exp14[k]);
    end
    applyStimulus(1'b0, 1'b1, 9'd32, 8'd13, 8'd0, 1'b0);
    checkOutput("blk latency", done_cyc, 254);
    checkOutput("blk so count", so_bits.size(), 112);
    for (int k = 0; k < 14; k++)
      checkOutput($sformatf("blk so w%0d", k), {24'd0, so_byte(k)}, {24'd0, exp14[k]});
    a_bad = 0;
    for (int k = 0; k < 14; k++)
      if (k >= a_seq.size() || a_seq[k] !== 9'(32 + k)) a_bad++;
    checkOutput("blk a steps", a_bad, 0);
    checkOutput("blk a count", a_seq.size(), 14);
    checkOutput("blk lat pulses", lat_pulses, 1);

    // Address wrap with BGN toggling and length/address/mode pins changing mid-block.
    wrap_a = '{9'd510, 9'd511, 9'd0, 9'd1};
    wrap_d = '{8'h12, 8'hF0, 8'h7E, 8'h81};
    for (int k = 0; k < 4; k++) preload(wrap_a[k], wrap_d[k]);
    applyStimulus(1'b0, 1'b1, 9'd510, 8'd3, 8'd0, 1'b1);
    checkOutput("wrap latency", done_cyc, 74);
    checkOutput("wrap a count", a_seq.size(), 4);
    a_bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (k >= a_seq.size() || a_seq[k] !== wrap_a[k]) a_bad++;
      if (so_byte(k) !== wrap_d[k]) a_bad++;
    end
    checkOutput("wrap a/so seq", a_bad, 0);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("no restart", {31'd0, bus.BUSY}, 32'd0);

    // Two-word MSB-first write at 100.
    preload(9'd100, 8'h00);
    preload(9'd101, 8'h00);
    tx_bytes.delete();
    tx_bytes.push_back(8'h3C);
    tx_bytes.push_back(8'hD7);
    applyStimulus(1'b1, 1'b1, 9'd100, 8'd1, 8'd0, 1'b0);
    checkOutput("wr2 mem100", {24'd0, mem[100]}, 32'h3C);
    checkOutput("wr2 mem101", {24'd0, mem[101]}, 32'hD7);
    checkOutput("wr2 we cycles", we_cycles, 2);
    checkOutput("wr2 lat gap", lat_gap, 0);
    checkOutput("wr2 lat pulses", lat_pulses, 1);
    checkOutput("wr2 latency", done_cyc, 35);

    // Reset during the second word of a three-word write: no further SRAM access.
    for (int k = 0; k < 3; k++) preload(9'(50 + k), 8'hEE);
    @(negedge CLK);
    bus.MODE = 1'b1; bus.MSB_FIRST = 1'b1; bus.ADDR_BGN = 9'd50;
    bus.DATA_LEN = 8'd2; bus.FREQ_DIV = 8'd0; bus.SPI_SI = 1'b1; bus.BGN = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(posedge CLK); #1;
      bus.BGN = 1'b0;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_outputs("abort");
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("abort mem50", {24'd0, mem[50]}, 32'hFF);
    checkOutput("abort mem51", {24'd0, mem[51]}, 32'hEE);
    checkOutput("abort busy", {31'd0, bus.BUSY}, 32'd0);
    tx_bytes.delete();
    tx_bytes.push_back(8'h5A);
    applyStimulus(1'b1, 1'b1, 9'd51, 8'd0, 8'd0, 1'b0);
    checkOutput("post-abort mem51", {24'd0, mem[51]}, 32'h5A);
    checkOutput("post-abort latency", done_cyc, 18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
